// File: rtl/tq_it4_post_pkg.sv
// Shared definitions for the tq inverse 4-point transform post-stages.
// Holds the DCT4 constants, default widths, the transpose-buffer FSM state
// type and a round-shift-clip helper shared by the first- and second-pass
// post-stages.
package tq_it4_post_pkg;

    // DCT4 basis constants (used by the multiplier stage that feeds this block).
    localparam int unsigned TQ_C64 = 64;
    localparam int unsigned TQ_C83 = 83;
    localparam int unsigned TQ_C36 = 36;

    // Default widths and shifts.
    localparam int unsigned TQ_IN_W     = 28;
    localparam int unsigned TQ_OUT_W    = 16;
    localparam int unsigned TQ_SHIFT_P1 = 7;
    localparam int unsigned TQ_SHIFT_P2 = 12;

    // Working width of the round-shift-clip helper.
    localparam int unsigned TQ_RSC_W = 64;

    typedef enum logic {
        StFill,
        StDrain
    } tr_state_e;

    // Adds half an LSB, shifts arithmetically (ties round toward +inf), then
    // saturates to a signed out_w-bit range. Caller keeps the low out_w bits.
    function automatic logic signed [TQ_RSC_W-1:0] tq_round_shift_clip(
        input logic signed [TQ_RSC_W-1:0] x,
        input int unsigned                shift,
        input int unsigned                out_w
    );
        logic signed [TQ_RSC_W-1:0] r;
        logic signed [TQ_RSC_W-1:0] hi;
        logic signed [TQ_RSC_W-1:0] lo;
        r  = (x + (64'sd1 <<< (shift - 1))) >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/tq_tr4x4_buf.sv
// 4x4 transpose buffer with fill/drain FSM.
// Rows are written one at a time (i_wr); once the fourth row lands the block
// is presented column by column under a valid/ready handshake.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   i_acc             a row was accepted upstream this cycle
//   o_in_ready        upstream may present a row (FILL and fewer than 4 taken)
//   i_wr, i_d0..i_d3  row write strobe and row elements (columns 0..3)
//   o_valid, i_out_ready  column handshake
//   o_col             index of the column currently presented
//   o_0..o_3          column elements, rows 0..3
module tq_tr4x4_buf
    import tq_it4_post_pkg::*;
#(
    parameter int unsigned OUT_W = TQ_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_acc,
    output logic             o_in_ready,
    input  logic             i_wr,
    input  logic [OUT_W-1:0] i_d0,
    input  logic [OUT_W-1:0] i_d1,
    input  logic [OUT_W-1:0] i_d2,
    input  logic [OUT_W-1:0] i_d3,
    output logic             o_valid,
    input  logic             i_out_ready,
    output logic [1:0]       o_col,
    output logic [OUT_W-1:0] o_0,
    output logic [OUT_W-1:0] o_1,
    output logic [OUT_W-1:0] o_2,
    output logic [OUT_W-1:0] o_3
);

    tr_state_e        r_state;
    tr_state_e        w_state_nxt;
    logic [2:0]       r_in_cnt;
    logic [1:0]       r_wr_row;
    logic [1:0]       r_col_cnt;
    logic [OUT_W-1:0] r_buf [4][4];
    logic [OUT_W-1:0] r_out [4];
    logic [OUT_W-1:0] w_din [4];
    logic             w_hs;
    logic             w_last_wr;
    logic             w_drain_done;

    assign w_din[0] = i_d0;
    assign w_din[1] = i_d1;
    assign w_din[2] = i_d2;
    assign w_din[3] = i_d3;

    assign w_hs         = (r_state == StDrain) & i_out_ready;
    assign w_last_wr    = i_wr & (r_wr_row == 2'd3);
    assign w_drain_done = w_hs & (r_col_cnt == 2'd3);

    assign o_in_ready = (r_state == StFill) & (r_in_cnt < 3'd4);
    assign o_valid    = (r_state == StDrain);
    assign o_col      = r_col_cnt;
    assign o_0        = r_out[0];
    assign o_1        = r_out[1];
    assign o_2        = r_out[2];
    assign o_3        = r_out[3];

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StFill:  if (w_last_wr)    w_state_nxt = StDrain;
            StDrain: if (w_drain_done) w_state_nxt = StFill;
            default: w_state_nxt = StFill;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= StFill;
            r_in_cnt  <= 3'd0;
            r_wr_row  <= 2'd0;
            r_col_cnt <= 2'd0;
            for (int r = 0; r < 4; r++) begin
                r_out[r] <= '0;
                for (int c = 0; c < 4; c++) begin
                    r_buf[r][c] <= '0;
                end
            end
        end else begin
            r_state <= w_state_nxt;

            if (w_drain_done) begin
                r_in_cnt <= 3'd0;
            end else if (i_acc) begin
                r_in_cnt <= r_in_cnt + 3'd1;
            end

            if (w_drain_done) begin
                r_wr_row <= 2'd0;
            end else if (i_wr) begin
                r_wr_row <= r_wr_row + 2'd1;
            end

            if (i_wr) begin
                r_buf[r_wr_row] <= w_din;
            end

            // Output registers hold the presented column so the outputs stay
            // put outside DRAIN. Row 3 of column 0 comes straight from the
            // write data because it lands in the buffer on this same edge.
            if (w_last_wr) begin
                r_col_cnt <= 2'd0;
                for (int r = 0; r < 3; r++) begin
                    r_out[r] <= r_buf[r][0];
                end
                r_out[3] <= w_din[0];
            end else if (w_hs) begin
                r_col_cnt <= r_col_cnt + 2'd1;
                if (!w_drain_done) begin
                    for (int r = 0; r < 4; r++) begin
                        r_out[r] <= r_buf[r][r_col_cnt + 2'd1];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tq_it4_post.sv
// Post-stage of the 4-point inverse transform.
// Takes one row of partial products (E0, E1, O1, O0) per handshake, runs the
// final butterfly, round-shifts and clips to OUT_W bits, and collects four
// rows in a transpose buffer that is emitted column by column.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   i_valid, i_ready    row handshake
//   i_0..i_3            E0, E1, O1, O0
//   o_valid, o_ready    column handshake
//   o_col               index of the column presented
//   o_0..o_3            column elements, rows 0..3
module tq_it4_post
    import tq_it4_post_pkg::*;
#(
    parameter int unsigned IN_W  = TQ_IN_W,
    parameter int unsigned SHIFT = TQ_SHIFT_P1,
    parameter int unsigned OUT_W = TQ_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic signed [IN_W-1:0]  i_0,
    input  logic signed [IN_W-1:0]  i_1,
    input  logic signed [IN_W-1:0]  i_2,
    input  logic signed [IN_W-1:0]  i_3,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [1:0]              o_col,
    output logic signed [OUT_W-1:0] o_0,
    output logic signed [OUT_W-1:0] o_1,
    output logic signed [OUT_W-1:0] o_2,
    output logic signed [OUT_W-1:0] o_3
);

    logic                       w_acc;
    logic signed [IN_W:0]       w_b [4];
    logic signed [IN_W:0]       r_b [4];
    logic                       r_v1;
    logic signed [TQ_RSC_W-1:0] w_rsc [4];
    logic [OUT_W-1:0]           r_r [4];
    logic                       r_v2;
    logic                       w_unused_rsc;

    assign w_acc = i_valid & i_ready;

    // Final butterfly, one bit of growth.
    assign w_b[0] = {i_0[IN_W-1], i_0} + {i_3[IN_W-1], i_3};
    assign w_b[1] = {i_1[IN_W-1], i_1} + {i_2[IN_W-1], i_2};
    assign w_b[2] = {i_1[IN_W-1], i_1} - {i_2[IN_W-1], i_2};
    assign w_b[3] = {i_0[IN_W-1], i_0} - {i_3[IN_W-1], i_3};

    for (genvar k = 0; k < 4; k++) begin : g_rsc
        assign w_rsc[k] = tq_round_shift_clip(
            $signed({{(TQ_RSC_W - IN_W - 1){r_b[k][IN_W]}}, r_b[k]}), SHIFT, OUT_W);
    end

    // Clipped values always fit in OUT_W bits; the upper bits are sign copies.
    assign w_unused_rsc = ^{w_rsc[0][TQ_RSC_W-1:OUT_W], w_rsc[1][TQ_RSC_W-1:OUT_W],
                            w_rsc[2][TQ_RSC_W-1:OUT_W], w_rsc[3][TQ_RSC_W-1:OUT_W]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_b[k] <= '0;
                r_r[k] <= '0;
            end
        end else begin
            r_v1 <= w_acc;
            r_v2 <= r_v1;
            if (w_acc) begin
                for (int k = 0; k < 4; k++) begin
                    r_b[k] <= w_b[k];
                end
            end
            if (r_v1) begin
                for (int k = 0; k < 4; k++) begin
                    r_r[k] <= w_rsc[k][OUT_W-1:0];
                end
            end
        end
    end

    tq_tr4x4_buf #(
        .OUT_W (OUT_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_acc       (w_acc),
        .o_in_ready  (i_ready),
        .i_wr        (r_v2),
        .i_d0        (r_r[0]),
        .i_d1        (r_r[1]),
        .i_d2        (r_r[2]),
        .i_d3        (r_r[3]),
        .o_valid     (o_valid),
        .i_out_ready (o_ready),
        .o_col       (o_col),
        .o_0         (o_0),
        .o_1         (o_1),
        .o_2         (o_2),
        .o_3         (o_3)
    );

endmodule

// File: tb/tb_tq_it4_post.sv
module tb_tq_it4_post;

    localparam int IN_W  = 28;
    localparam int OUT_W = 16;
    localparam int SHIFT = 7;

    typedef struct packed {
        logic [3:0][IN_W-1:0]  x;
        logic [3:0][OUT_W-1:0] y;
    } item_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    i_valid;
    logic                    i_ready;
    logic signed [IN_W-1:0]  i_0, i_1, i_2, i_3;
    logic                    o_valid;
    logic                    o_ready;
    logic [1:0]              o_col;
    logic signed [OUT_W-1:0] o_0, o_1, o_2, o_3;
    logic signed [OUT_W-1:0] o_arr [4];

    int n_tests = 0;
    int n_fail  = 0;

    item_t                 inq[$];
    logic [3:0][OUT_W-1:0] mq[$];

    assign o_arr[0] = o_0;
    assign o_arr[1] = o_1;
    assign o_arr[2] = o_2;
    assign o_arr[3] = o_3;

    always #5 clk = ~clk;

    tq_it4_post #(
        .IN_W  (IN_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_0     (i_0),
        .i_1     (i_1),
        .i_2     (i_2),
        .i_3     (i_3),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_col   (o_col),
        .o_0     (o_0),
        .o_1     (o_1),
        .o_2     (o_2),
        .o_3     (o_3)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Round half up via floor division, then saturate.
    function automatic longint model_elem(input longint b);
        longint d, v, q;
        d = longint'(1) << SHIFT;
        v = b + d / 2;
        if (v >= 0) q = v / d;
        else        q = -((-v + d - 1) / d);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    function automatic logic [3:0][OUT_W-1:0] model_row(input logic [3:0][IN_W-1:0] x);
        longint e0, e1, o1, o0, q;
        longint b [4];
        logic [3:0][OUT_W-1:0] res;
        e0 = longint'($signed(x[0]));
        e1 = longint'($signed(x[1]));
        o1 = longint'($signed(x[2]));
        o0 = longint'($signed(x[3]));
        b[0] = e0 + o0;
        b[1] = e1 + o1;
        b[2] = e1 - o1;
        b[3] = e0 - o0;
        for (int k = 0; k < 4; k++) begin
            q = model_elem(b[k]);
            res[k] = q[OUT_W-1:0];
        end
        return res;
    endfunction

    task automatic push_dir(input longint a, input longint b, input longint c, input longint d,
                            input longint y0, input longint y1, input longint y2,
                            input longint y3);
        item_t it;
        it.x[0] = a[IN_W-1:0];
        it.x[1] = b[IN_W-1:0];
        it.x[2] = c[IN_W-1:0];
        it.x[3] = d[IN_W-1:0];
        it.y[0] = y0[OUT_W-1:0];
        it.y[1] = y1[OUT_W-1:0];
        it.y[2] = y2[OUT_W-1:0];
        it.y[3] = y3[OUT_W-1:0];
        inq.push_back(it);
    endtask

    task automatic push_rand(input int n);
        item_t it;
        int    v;
        for (int r = 0; r < n; r++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    it.x[k] = IN_W'($urandom());
                end else begin
                    v = int'($urandom_range(0, 16777215)) - 8388608;
                    it.x[k] = v[IN_W-1:0];
                end
            end
            it.y = model_row(it.x);
            inq.push_back(it);
        end
    endtask

    // mode 0: o_ready=1, mode 1: 1,0,0 repeating, else random.
    task automatic run(input int mode, input bit stop_sent, input int budget);
        int               tail = 0;
        int               acc_blk = 0;
        int               t4 = -100;
        int               exp_col = 0;
        bit               done = 0;
        bit               prev_v = 0;
        bit               prev_stall = 0;
        bit               prev_last = 0;
        bit               hs, acc;
        logic [OUT_W-1:0] po [4];
        logic [1:0]       pcol = 2'd0;
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            @(negedge clk);
            if (inq.size() > 0) begin
                i_valid = 1'b1;
                i_0 = inq[0].x[0];
                i_1 = inq[0].x[1];
                i_2 = inq[0].x[2];
                i_3 = inq[0].x[3];
            end else begin
                i_valid = 1'b0;
            end
            case (mode)
                0:       o_ready = 1'b1;
                1:       o_ready = ((cyc % 3) == 0);
                default: o_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (prev_stall) begin
                chk("stall_valid", o_valid, 1);
                chk("stall_col", o_col, pcol);
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("stall_hold_%0d", k), o_arr[k], $signed(po[k]));
                end
            end
            if (prev_last) chk("iready_after_drain", i_ready, 1);
            if (o_valid && !prev_v) chk("latency", cyc - t4, 3);
            if (o_valid) chk("iready_in_drain", i_ready, 0);
            hs  = o_valid && o_ready;
            acc = i_valid && i_ready;
            prev_last = 0;
            if (hs) begin
                chk("col_idx", o_col, exp_col);
                chk("block_expected", mq.size() >= 4, 1);
                if (mq.size() >= 4) begin
                    for (int k = 0; k < 4; k++) begin
                        chk($sformatf("col%0d_row%0d", exp_col, k), o_arr[k],
                            $signed(mq[k][exp_col]));
                    end
                end
                if (exp_col == 3) begin
                    prev_last = 1;
                    exp_col = 0;
                    for (int k = 0; k < 4 && mq.size() > 0; k++) void'(mq.pop_front());
                end else begin
                    exp_col++;
                end
            end
            prev_stall = o_valid && !o_ready;
            prev_v     = o_valid;
            pcol       = o_col;
            for (int k = 0; k < 4; k++) po[k] = o_arr[k];
            if (acc) begin
                mq.push_back(inq[0].y);
                void'(inq.pop_front());
                acc_blk++;
                if (acc_blk == 4) begin
                    t4 = cyc;
                    acc_blk = 0;
                end
            end
            @(posedge clk);
            if (stop_sent) begin
                if (inq.size() == 0) begin
                    tail++;
                    if (tail >= 4) done = 1;
                end
            end else if (inq.size() == 0 && mq.size() == 0 && !prev_last) begin
                done = 1;
            end
        end
        #1 i_valid = 1'b0;
        if (!stop_sent) chk("run_complete", inq.size() + mq.size(), 0);
    endtask

    initial begin
        rst     = 1'b0;
        i_valid = 1'b0;
        i_0     = '0;
        i_1     = '0;
        i_2     = '0;
        i_3     = '0;
        o_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_o_valid", o_valid, 0);
        chk("reset_i_ready", i_ready, 1);
        chk("reset_o_col", o_col, 0);
        for (int k = 0; k < 4; k++) chk($sformatf("reset_o_%0d", k), o_arr[k], 0);
        rst = 1'b1;

        // Two rows then reset mid-fill; they must never appear.
        push_rand(2);
        run(0, 1, 50);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_o_valid", o_valid, 0);
        chk("midrst_i_ready", i_ready, 1);
        chk("midrst_o_col", o_col, 0);
        for (int k = 0; k < 4; k++) chk($sformatf("midrst_o_%0d", k), o_arr[k], 0);
        @(negedge clk);
        rst = 1'b1;
        inq.delete();
        mq.delete();

        // DC rows.
        for (int r = 0; r < 4; r++) push_dir(640, 640, 0, 0, 5, 5, 5, 5);
        run(0, 0, 100);

        // Rounding, sign and clipping.
        push_dir(1000, -65, 0, 200, 9, -1, -1, 6);
        push_dir(0, -64, 0, 0, 0, 0, 0, 0);
        push_dir(64'sd1 <<< 26, 0, 0, 64'sd1 <<< 26, 32767, 0, 0, 0);
        push_dir(-(64'sd1 <<< 26), 0, 0, 64'sd1 <<< 26, 0, 0, 0, -32768);
        run(2, 0, 200);

        // Transpose: buf[r][c] = 10r + c, with 1,0,0 backpressure.
        for (int r = 0; r < 4; r++) begin
            push_dir(64 * (20 * r + 3), 64 * (20 * r + 3), -64, -192,
                     10 * r, 10 * r + 1, 10 * r + 2, 10 * r + 3);
        end
        run(1, 0, 200);

        // Back-to-back: eight rows queued with i_valid held high.
        push_rand(8);
        run(2, 0, 400);

        push_rand(4);
        run(0, 0, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
